// File: rtl/change_dispenser.sv
// Refund coin payout: converts a remaining balance into coins, largest first,
// one coin per ejector handshake, then reports count, value paid and residue.
module change_dispenser #(
    parameter int BAL_W = 32,
    parameter int COIN0 = 100,
    parameter int COIN1 = 500,
    parameter int COIN2 = 1000,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic [BAL_W-1:0] i_balance,
    input  logic             i_coin_ack,
    output logic             o_ready,
    output logic             o_coin_valid,
    output logic [2:0]       o_return_coin,
    output logic             o_done,
    output logic [CNT_W-1:0] o_coin_count,
    output logic [BAL_W-1:0] o_total_paid,
    output logic [BAL_W-1:0] o_residue
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DISPENSE = 2'd1,
        DONE     = 2'd2
    } state_t;

    localparam logic [BAL_W-1:0] C0 = BAL_W'(COIN0);
    localparam logic [BAL_W-1:0] C1 = BAL_W'(COIN1);
    localparam logic [BAL_W-1:0] C2 = BAL_W'(COIN2);
    localparam logic [3*BAL_W-1:0] COIN_VALS = {C2, C1, C0};

    state_t           state_reg, state_next;
    logic [BAL_W-1:0] rem_reg, rem_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [BAL_W-1:0] total_reg, total_next;
    logic [BAL_W-1:0] residue_reg, residue_next;

    logic [2:0]       fits;
    logic [2:0]       coin_sel;
    logic [BAL_W-1:0] coin_part [3];
    logic [BAL_W-1:0] coin_value;

    // Coin values ascend with index, so 'fits' is thermometer-coded and the
    // largest payable coin is the highest set bit.
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_coin
            assign fits[gi] = (rem_reg >= COIN_VALS[gi*BAL_W +: BAL_W]);
            if (gi == 2) begin : g_top
                assign coin_sel[gi] = fits[gi];
            end else begin : g_low
                assign coin_sel[gi] = fits[gi] & ~fits[gi+1];
            end
            assign coin_part[gi] = coin_sel[gi] ? COIN_VALS[gi*BAL_W +: BAL_W] : '0;
        end
    endgenerate

    assign coin_value = coin_part[0] | coin_part[1] | coin_part[2];

    always_comb begin
        state_next   = state_reg;
        rem_next     = rem_reg;
        count_next   = count_reg;
        total_next   = total_reg;
        residue_next = residue_reg;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    rem_next     = i_balance;
                    count_next   = '0;
                    total_next   = '0;
                    residue_next = '0;
                    state_next   = (i_balance >= C0) ? DISPENSE : DONE;
                end
            end
            DISPENSE: begin
                if (i_coin_ack) begin
                    rem_next   = rem_reg - coin_value;
                    total_next = total_reg + coin_value;
                    if (count_reg != '1) begin
                        count_next = count_reg + 1'b1;
                    end
                    if (rem_next < C0) begin
                        state_next = DONE;
                    end
                end
            end
            DONE: begin
                residue_next = rem_reg;
                state_next   = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            rem_reg     <= '0;
            count_reg   <= '0;
            total_reg   <= '0;
            residue_reg <= '0;
        end else begin
            state_reg   <= state_next;
            rem_reg     <= rem_next;
            count_reg   <= count_next;
            total_reg   <= total_next;
            residue_reg <= residue_next;
        end
    end

    // Residue becomes visible in the DONE cycle itself, then is held.
    assign o_ready       = (state_reg == IDLE);
    assign o_coin_valid  = (state_reg == DISPENSE);
    assign o_return_coin = (state_reg == DISPENSE) ? coin_sel : 3'b000;
    assign o_done        = (state_reg == DONE);
    assign o_coin_count  = count_reg;
    assign o_total_paid  = total_reg;
    assign o_residue     = (state_reg == DONE) ? rem_reg : residue_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: refunds with hand-computed coin
// sequences, stalls, ignored starts, saturation and asynchronous reset.
module tb_change_dispenser;

    logic        clk;
    logic        reset;
    logic        i_start;
    logic [31:0] i_balance;
    logic        i_coin_ack;
    logic        o_ready;
    logic        o_coin_valid;
    logic [2:0]  o_return_coin;
    logic        o_done;
    logic [7:0]  o_coin_count;
    logic [31:0] o_total_paid;
    logic [31:0] o_residue;

    int checks = 0;
    int errors = 0;

    change_dispenser dut (
        .clk           (clk),
        .reset         (reset),
        .i_start       (i_start),
        .i_balance     (i_balance),
        .i_coin_ack    (i_coin_ack),
        .o_ready       (o_ready),
        .o_coin_valid  (o_coin_valid),
        .o_return_coin (o_return_coin),
        .o_done        (o_done),
        .o_coin_count  (o_coin_count),
        .o_total_paid  (o_total_paid),
        .o_residue     (o_residue)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check_val({tag, "_ready"}, 32'(o_ready), 32'd1);
        check_val({tag, "_valid"}, 32'(o_coin_valid), 32'd0);
        check_val({tag, "_coin"}, 32'(o_return_coin), 32'd0);
        check_val({tag, "_done"}, 32'(o_done), 32'd0);
        check_val({tag, "_count"}, 32'(o_coin_count), 32'd0);
        check_val({tag, "_total"}, o_total_paid, 32'd0);
        check_val({tag, "_residue"}, o_residue, 32'd0);
    endtask

    // coins: expected one-hot coin k in bits [3k+2:3k], up to 8 coins.
    task automatic refund(input string name, input logic [31:0] bal, input int n_coins,
                          input logic [23:0] coins, input int stall, input bit inject,
                          input logic [31:0] exp_total, input logic [31:0] exp_res);
        i_start    = 1'b1;
        i_balance  = bal;
        i_coin_ack = (stall == 0);
        tick();
        i_start   = 1'b0;
        i_balance = $urandom;
        for (int k = 0; k < n_coins; k++) begin
            int hold;
            hold = (k == 0) ? stall : 0;
            for (int s = 0; s <= hold; s++) begin
                i_coin_ack = (s == hold);
                if (inject && k == 0 && s == 0) begin
                    i_start   = 1'b1;
                    i_balance = 32'd9999;
                end else begin
                    i_start = 1'b0;
                end
                check_val({name, "_valid"}, 32'(o_coin_valid), 32'd1);
                check_val({name, "_ready"}, 32'(o_ready), 32'd0);
                check_val({name, "_coin"}, 32'(o_return_coin), 32'(coins[3*k +: 3]));
                tick();
            end
        end
        i_start    = 1'b0;
        i_coin_ack = 1'b0;
        check_val({name, "_done"}, 32'(o_done), 32'd1);
        check_val({name, "_dvalid"}, 32'(o_coin_valid), 32'd0);
        check_val({name, "_dcoin"}, 32'(o_return_coin), 32'd0);
        check_val({name, "_count"}, 32'(o_coin_count), 32'(n_coins));
        check_val({name, "_total"}, o_total_paid, exp_total);
        check_val({name, "_residue"}, o_residue, exp_res);
        tick();
        check_val({name, "_done_low"}, 32'(o_done), 32'd0);
        check_val({name, "_ready_again"}, 32'(o_ready), 32'd1);
        check_val({name, "_count_hold"}, 32'(o_coin_count), 32'(n_coins));
        check_val({name, "_residue_hold"}, o_residue, exp_res);
        $display("refund %s bal=%0d coins=%0d total=%0d residue=%0d", name, bal,
                 o_coin_count, o_total_paid, o_residue);
    endtask

    initial begin
        reset      = 1'b1;
        i_start    = 1'b0;
        i_balance  = '0;
        i_coin_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_values("rst");
        tick();

        refund("b1600", 32'd1600, 3, {15'd0, 3'b001, 3'b010, 3'b100}, 0, 1'b0, 32'd1600, 32'd0);
        refund("b2050", 32'd2050, 2, {18'd0, 3'b100, 3'b100}, 0, 1'b0, 32'd2000, 32'd50);
        refund("b0", 32'd0, 0, 24'd0, 0, 1'b0, 32'd0, 32'd0);
        refund("b99", 32'd99, 0, 24'd0, 0, 1'b0, 32'd0, 32'd99);
        refund("b600_stall", 32'd600, 2, {18'd0, 3'b001, 3'b010}, 5, 1'b0, 32'd600, 32'd0);
        refund("b1500_inject", 32'd1500, 2, {18'd0, 3'b010, 3'b100}, 0, 1'b1, 32'd1500, 32'd0);
        refund("b100", 32'd100, 1, {21'd0, 3'b001}, 0, 1'b0, 32'd100, 32'd0);
        refund("b1099", 32'd1099, 1, {21'd0, 3'b100}, 0, 1'b0, 32'd1000, 32'd99);
        refund("b1799", 32'd1799, 4, {12'd0, 3'b001, 3'b001, 3'b010, 3'b100}, 2, 1'b0, 32'd1700, 32'd99);

        // Counter saturation: 260 coins of 1000 against an 8-bit count.
        begin
            int cyc;
            bit seen_done;
            i_start    = 1'b1;
            i_balance  = 32'd260000;
            i_coin_ack = 1'b1;
            tick();
            i_start   = 1'b0;
            cyc       = 0;
            seen_done = 1'b0;
            while (!seen_done && cyc < 400) begin
                if (o_done) seen_done = 1'b1;
                else begin
                    tick();
                    cyc++;
                end
            end
            i_coin_ack = 1'b0;
            check_val("sat_done_seen", 32'(seen_done), 32'd1);
            check_val("sat_cycles", 32'(cyc), 32'd260);
            check_val("sat_count", 32'(o_coin_count), 32'd255);
            check_val("sat_total", o_total_paid, 32'd260000);
            check_val("sat_residue", o_residue, 32'd0);
            $display("refund sat bal=260000 coins=%0d total=%0d residue=%0d",
                     o_coin_count, o_total_paid, o_residue);
            tick();
        end

        // Asynchronous reset between edges in the middle of a refund.
        i_start    = 1'b1;
        i_balance  = 32'd1600;
        i_coin_ack = 1'b0;
        tick();
        i_start = 1'b0;
        check_val("arst_pre_valid", 32'(o_coin_valid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("arst");
        @(posedge clk);
        #1;
        check_val("arst_hold_done", 32'(o_done), 32'd0);
        reset = 1'b0;
        #2;
        check_reset_values("arst_rel");
        $display("refund arst bal=1600 aborted by reset");
        tick();
        refund("after_rst", 32'd1600, 3, {15'd0, 3'b001, 3'b010, 3'b100}, 0, 1'b0, 32'd1600, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
